// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with single-cycle hits.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_dm #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_flush,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int unsigned DEPTH = LINES * WORDS_PER_LINE;
  localparam int unsigned SEL_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [DEPTH];

  logic               mem_req_q, mem_we_q;
  logic [3:0]         mem_be_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;

  logic [CNT_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [SEL_W-1:0]   rd_sel, fill_sel;
  logic [ADDR_W-1:0]  line_base, word_addr;
  logic               hit, beat, last_beat;

  assign cpu_off   = CNT_W'((cpu_addr >> 2) & ADDR_W'(WORDS_PER_LINE - 1));
  assign cpu_idx   = IDX_W'(cpu_addr >> (2 + OFF_W));
  assign cpu_tag   = TAG_W'(cpu_addr >> (2 + OFF_W + IDX_W));
  assign rd_sel    = (SEL_W'(cpu_idx) << OFF_W) | SEL_W'(cpu_off);
  assign fill_sel  = (SEL_W'(cpu_idx) << OFF_W) | SEL_W'(cnt_q);
  assign line_base = cpu_addr & ~ADDR_W'(WORDS_PER_LINE * 4 - 1);
  assign word_addr = cpu_addr & ~ADDR_W'(3);
  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // Acks are only meaningful while a request is actually outstanding.
  assign beat      = mem_ack && mem_req_q;
  assign last_beat = beat && (cnt_q == LAST);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_d = StWrite;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_q[rd_sel];
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (last_beat) state_d = StIdle;
      end
      StWrite: begin
        if (beat) begin
          cpu_ready = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            if (cpu_we) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_be_q    <= cpu_be;
              mem_addr_q  <= word_addr;
              mem_wdata_q <= cpu_wdata;
            end else if (!hit) begin
              mem_req_q        <= 1'b1;
              mem_we_q         <= 1'b0;
              mem_be_q         <= 4'hF;
              mem_addr_q       <= line_base;
              mem_wdata_q      <= '0;
              cnt_q            <= '0;
              valid_q[cpu_idx] <= 1'b0;
            end
          end else if (cpu_flush) begin
            valid_q <= '0;
          end
        end
        StFill: begin
          if (last_beat) begin
            valid_q[cpu_idx] <= 1'b1;
            cnt_q            <= '0;
            mem_req_q        <= 1'b0;
            mem_be_q         <= '0;
            mem_addr_q       <= '0;
          end else if (beat) begin
            cnt_q      <= cnt_q + 1'b1;
            mem_addr_q <= line_base | (ADDR_W'(cnt_q + 1'b1) << 2);
          end
        end
        StWrite: begin
          if (beat) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; validity alone guards their contents.
  always_ff @(posedge clock) begin
    if (state_q == StFill && beat) begin
      data_q[fill_sel] <= mem_rdata;
      if (cnt_q == LAST) tag_q[cpu_idx] <= cpu_tag;
    end
    if (state_q == StWrite && beat && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_be[b]) data_q[rd_sel][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, misses_q;
  logic        load_hit;

  assign load_hit    = (state_q == StIdle) && cpu_req && !cpu_we && hit;
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (load_hit) hits_q <= hits_q + 32'd1;
      if (state_q == StIdle && state_d == StFill) misses_q <= misses_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: word-addressed memory model with a gated 1-cycle ack.
module tb_dcache_dm;

  logic        clock, reset;
  logic        cpu_req, cpu_we, cpu_flush;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  logic [31:0] mem_model [0:1023];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [3:0]  wr_be_log[$];
  bit          ack_en;
  int          checks, failures;

  dcache_dm dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory responder: ack whatever request is visible at the falling edge.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ack   = mem_req && ack_en;
      mem_rdata = mem_model[mem_addr[11:2]];
    end
  end

  // Beats complete on the rising edge; log them and apply writes to the model.
  always @(posedge clock) begin
    if (reset && mem_req && mem_ack) begin
      if (mem_we) begin
        wr_addr_log.push_back(mem_addr);
        wr_be_log.push_back(mem_be);
        wr_data_log.push_back(mem_wdata);
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_model[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        rd_log.push_back(mem_addr);
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic flush,
                         output logic [31:0] d, output int cyc);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_be = '0; cpu_wdata = '0;
    cpu_flush = flush;
    #1;
    cyc = 0;
    while (!cpu_ready && cyc < 20) begin
      @(negedge clock); #1; cyc++;
    end
    if (!cpu_ready) cyc = -1;
    d = cpu_rdata;
    @(posedge clock); #1;
    cpu_req = 1'b0; cpu_flush = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                          output int cyc, output logic ready_after);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
    #1;
    cyc = 0;
    while (!cpu_ready && cyc < 20) begin
      @(negedge clock); #1; cyc++;
    end
    if (!cpu_ready) cyc = -1;
    @(posedge clock); #1;
    ready_after = cpu_ready;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", cpu_ready); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_be got %h want 0", mem_be); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_cold_load();
    logic [31:0] d;
    logic [31:0] exp_addr [4];
    int cyc;
    exp_addr = '{32'h40, 32'h44, 32'h48, 32'h4C};
    rd_log.delete();
    do_load(32'h40, 1'b0, d, cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL cold_cycles got %0d want 5", cyc); end
    checks++; if (d !== 32'd7) begin failures++; $display("FAIL cold_rdata got %h want 7", d); end
    checks++; if (rd_log.size() !== 4) begin failures++; $display("FAIL cold_beats got %0d want 4", rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) begin
        checks++;
        if (rd_log[i] !== exp_addr[i]) begin
          failures++; $display("FAIL cold_beat_addr%0d got %h want %h", i, rd_log[i], exp_addr[i]);
        end
      end
    end
    do_load(32'h48, 1'b0, d, cyc);
    checks++; if (cyc !== 0) begin failures++; $display("FAIL hit_cycles got %0d want 0", cyc); end
    checks++; if (d !== 32'd9) begin failures++; $display("FAIL hit_rdata got %h want 9", d); end
    checks++; if (rd_log.size() !== 4) begin failures++; $display("FAIL hit_no_beats got %0d want 4", rd_log.size()); end
`ifdef DCACHE_STATS_EN
    checks++; if (stat_misses !== 32'd1) begin failures++; $display("FAIL stat_misses got %0d want 1", stat_misses); end
    checks++; if (stat_hits !== 32'd2) begin failures++; $display("FAIL stat_hits got %0d want 2", stat_hits); end
`endif
  endtask

  task automatic test_store_hit();
    logic [31:0] d;
    logic ra;
    int cyc;
    wr_addr_log.delete(); wr_be_log.delete(); wr_data_log.delete();
    do_store(32'h44, 4'b0011, 32'hAAAABBBB, cyc, ra);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL sthit_cycles got %0d want 1", cyc); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL sthit_ready_twice got %b want 0", ra); end
    checks++; if (wr_addr_log.size() !== 1) begin failures++; $display("FAIL sthit_writes got %0d want 1", wr_addr_log.size()); end
    if (wr_addr_log.size() == 1) begin
      checks++; if (wr_addr_log[0] !== 32'h44) begin failures++; $display("FAIL sthit_addr got %h want 44", wr_addr_log[0]); end
      checks++; if (wr_be_log[0] !== 4'h3) begin failures++; $display("FAIL sthit_be got %h want 3", wr_be_log[0]); end
      checks++; if (wr_data_log[0] !== 32'hAAAABBBB) begin failures++; $display("FAIL sthit_wdata got %h want aaaabbbb", wr_data_log[0]); end
    end
    do_load(32'h44, 1'b0, d, cyc);
    checks++; if (cyc !== 0) begin failures++; $display("FAIL merged_cycles got %0d want 0", cyc); end
    checks++; if (d !== 32'h0000BBBB) begin failures++; $display("FAIL merged_rdata got %h want 0000bbbb", d); end
  endtask

  task automatic test_store_miss();
    logic [31:0] d;
    int cyc;
    rd_log.delete(); wr_addr_log.delete(); wr_be_log.delete(); wr_data_log.delete();
    ack_en = 1'b0;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h400; cpu_be = 4'hF; cpu_wdata = 32'h12345678;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL stall_req got %b want 1", mem_req); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL stall_we got %b want 1", mem_we); end
    checks++; if (mem_addr !== 32'h400) begin failures++; $display("FAIL stall_addr got %h want 400", mem_addr); end
    checks++; if (mem_be !== 4'hF) begin failures++; $display("FAIL stall_be got %h want f", mem_be); end
    checks++; if (mem_wdata !== 32'h12345678) begin failures++; $display("FAIL stall_wdata got %h want 12345678", mem_wdata); end
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got %b want 0", cpu_ready); end
    ack_en = 1'b1;
    cyc = 0;
    while (!cpu_ready && cyc < 20) begin
      @(negedge clock); #1; cyc++;
    end
    checks++; if (cyc !== 1) begin failures++; $display("FAIL stmiss_cycles got %0d want 1", cyc); end
    @(posedge clock); #1;
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL stmiss_ready_twice got %b want 0", cpu_ready); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stmiss_req_drop got %b want 0", mem_req); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    checks++; if (wr_addr_log.size() !== 1) begin failures++; $display("FAIL stmiss_writes got %0d want 1", wr_addr_log.size()); end
    checks++; if (rd_log.size() !== 0) begin failures++; $display("FAIL stmiss_reads got %0d want 0", rd_log.size()); end
    do_load(32'h400, 1'b0, d, cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL noalloc_cycles got %0d want 5", cyc); end
    checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL noalloc_rdata got %h want 12345678", d); end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    int cyc;
    do_load(32'h000, 1'b0, d, cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL conf0_cycles got %0d want 5", cyc); end
    checks++; if (d !== 32'h10000000) begin failures++; $display("FAIL conf0_rdata got %h want 10000000", d); end
    do_load(32'h100, 1'b0, d, cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL conf1_cycles got %0d want 5", cyc); end
    checks++; if (d !== 32'h10000040) begin failures++; $display("FAIL conf1_rdata got %h want 10000040", d); end
    do_load(32'h000, 1'b0, d, cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL conf2_cycles got %0d want 5", cyc); end
    checks++; if (d !== 32'h10000000) begin failures++; $display("FAIL conf2_rdata got %h want 10000000", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int cyc;
    do_load(32'h48, 1'b1, d, cyc);
    checks++; if (cyc !== 0) begin failures++; $display("FAIL flush_req_wins_cycles got %0d want 0", cyc); end
    do_load(32'h48, 1'b0, d, cyc);
    checks++; if (cyc !== 0) begin failures++; $display("FAIL flush_ignored_cycles got %0d want 0", cyc); end
    @(negedge clock); cpu_flush = 1'b1;
    @(negedge clock); cpu_flush = 1'b0;
    do_load(32'h48, 1'b0, d, cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL flushed_cycles got %0d want 5", cyc); end
    checks++; if (d !== 32'd9) begin failures++; $display("FAIL flushed_rdata got %h want 9", d); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d;
    int cyc;
    rd_log.delete();
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL abort_req got %b want 0", mem_req); end
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got %b want 0", cpu_ready); end
    checks++; if (rd_log.size() !== 2) begin failures++; $display("FAIL abort_beats got %0d want 2", rd_log.size()); end
    cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rd_log.delete();
    do_load(32'h80, 1'b0, d, cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL refill_cycles got %0d want 5", cyc); end
    checks++; if (d !== 32'h10000020) begin failures++; $display("FAIL refill_rdata got %h want 10000020", d); end
    checks++; if (rd_log.size() !== 4) begin failures++; $display("FAIL refill_beats got %0d want 4", rd_log.size()); end
    if (rd_log.size() == 4) begin
      checks++; if (rd_log[0] !== 32'h80) begin failures++; $display("FAIL refill_first got %h want 80", rd_log[0]); end
      checks++; if (rd_log[3] !== 32'h8C) begin failures++; $display("FAIL refill_last got %h want 8c", rd_log[3]); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; ack_en = 1'b1;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0;
    cpu_wdata = '0; cpu_flush = 1'b0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h10000000 + i;
    mem_model[16] = 32'd7; mem_model[17] = 32'd8; mem_model[18] = 32'd9; mem_model[19] = 32'd10;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
